ppl_dmem_arbiter: RTL

- Shares the single-port pipeline data RAM (32 words, word index addr[6:2]) between the pipeline MEM stage (port C) and an I/O/loader master (port I).
- Grants at most one access per clk cycle and drives the RAM address, write-data and write-enable inputs.
- Stalls the pipeline when port C loses arbitration.
- CPU has priority; a starvation counter and a lock state guarantee port I forward progress and atomic sequences.

---
 rtl/ppl_defs.sv | 17 +
 rtl/ppl_arb_starve_cnt.sv | 45 ++++
 rtl/ppl_dmem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ppl_defs.sv
// Shared definitions for the pipeline data-memory path: arbiter FSM states,
// the default starvation limit, and the data-memory geometry.
package ppl_defs;

  typedef enum logic {
    S_NORM = 1'b0,
    S_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_STARVE_CNT_W = 3;

  // Geometry shared with the data-memory wrapper.
  localparam int DMEM_IDX_W  = 5;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/ppl_arb_starve_cnt.sv
// Saturating count of consecutive cycles the I/O master has lost arbitration;
// at_limit_o tells the arbiter to force an I/O grant.
module ppl_arb_starve_cnt
  import ppl_defs::*;
#(
  parameter int CNT_W = DEF_STARVE_CNT_W,
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  // CNT_W has to be wide enough to hold LIMIT itself.
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_limit_o = (cnt_q == LIMIT_C);

  // NOTE: combinational blocks assign a default first so every path drives
  // cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ppl_dmem_arbiter.sv
// Single-port data RAM arbiter between the pipeline MEM stage (port C) and an
// I/O/loader master (port I): CPU priority, starvation escape, and lock.
module ppl_dmem_arbiter
  import ppl_defs::*;
#(
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int IDX_W        = DMEM_IDX_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = DEF_STARVE_CNT_W
) (
  input  logic              clk,
  input  logic              clrn,
  // Port C: pipeline MEM stage
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  // Port I: I/O / loader master
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_lock,
  input  logic [31:0]       i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // RAM side
  output logic [IDX_W-1:0]  m_addr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_dout
);

  arb_state_e        state_q;
  logic              c_req_v;
  logic              i_req_v;
  logic              c_gnt;
  logic              at_limit;
  logic              i_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [IDX_W-1:0]  c_idx;
  logic [IDX_W-1:0]  i_idx;

  // Only the word index is decoded; the rest of each address aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:IDX_W+2], c_addr[1:0],
                              i_addr[31:IDX_W+2], i_addr[1:0]};

  assign c_idx = c_addr[IDX_W+1:2];
  assign i_idx = i_addr[IDX_W+1:2];

  // Requests are clamped while in reset so nothing is granted or written.
  assign c_req_v = c_req & clrn;
  assign i_req_v = i_req & clrn;

  always_comb begin
    i_gnt = 1'b0;
    c_gnt = 1'b0;
    case (state_q)
      S_NORM: begin
        i_gnt = i_req_v & (~c_req_v | at_limit);
        c_gnt = c_req_v & ~i_gnt;
      end
      S_LOCK: begin
        i_gnt = i_req_v;
        c_gnt = 1'b0;
      end
      default: begin
        i_gnt = 1'b0;
        c_gnt = 1'b0;
      end
    endcase
  end

  ppl_arb_starve_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .clrn       (clrn),
    .clr_i      (i_gnt | ~i_req_v),
    .inc_i      (i_req_v & ~i_gnt),
    .at_limit_o (at_limit)
  );

  // With no grant the address follows port C and the write enable stays low.
  always_comb begin
    m_addr = c_idx;
    m_din  = c_wdata;
    m_we   = 1'b0;
    if (i_gnt) begin
      m_addr = i_idx;
      m_din  = i_wdata;
      m_we   = i_we;
    end else if (c_gnt) begin
      m_we   = c_we;
    end
  end

  assign c_rdata = m_dout;
  assign c_stall = c_req_v & ~c_gnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_NORM;
    end else begin
      case (state_q)
        S_NORM: if (i_gnt && i_lock) state_q <= S_LOCK;
        S_LOCK: if (!i_req_v || (i_gnt && !i_lock)) state_q <= S_NORM;
        default: state_q <= S_NORM;
      endcase
    end
  end

  // NOTE: i_rdata is reset too, because its post-reset value is visible on
  // the port; pure storage arrays would be left unreset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= i_gnt & ~i_we;
      if (i_gnt && !i_we) begin
        i_rdata_q <= m_dout;
      end
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;

endmodule
